// File: rtl/bsg_mux_one_hot_pipe_if.sv
// Handshake bundle for bsg_mux_one_hot_pipe: upstream beat in, buffered beat out.
// slave = the pipe's own view, master = the view of whoever drives it.
interface bsg_mux_one_hot_pipe_if #(
  parameter int width_p         = 41,
  parameter int els_p           = 4,
  parameter int err_cnt_width_p = 8
);
  logic                       v_i;
  logic                       ready_o;
  logic [els_p*width_p-1:0]   data_i;
  logic [els_p-1:0]           sel_one_hot_i;
  logic                       v_o;
  logic                       ready_i;
  logic [width_p-1:0]         data_o;
  logic                       sel_err_o;
  logic [err_cnt_width_p-1:0] err_cnt_o;

  modport slave (
    input  v_i, data_i, sel_one_hot_i, ready_i,
    output ready_o, v_o, data_o, sel_err_o, err_cnt_o
  );

  modport master (
    output v_i, data_i, sel_one_hot_i, ready_i,
    input  ready_o, v_o, data_o, sel_err_o, err_cnt_o
  );
endinterface

// File: rtl/bsg_mux_one_hot_pipe.sv
// One-hot AND/OR mux feeding a 2-entry elastic output buffer, with a
// non-one-hot select flag carried per beat and a saturating error counter.
module bsg_mux_one_hot_pipe #(
  parameter int width_p         = 41,
  parameter int els_p           = 4,
  parameter int check_one_hot_p = 1,
  parameter int err_cnt_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  bsg_mux_one_hot_pipe_if.slave  pipe_io
);

  typedef struct packed {
    logic               err;
    logic [width_p-1:0] data;
  } entry_t;

  logic [width_p-1:0] mux_data;
  logic               sel_err;
  logic               enq, deq;
  logic [1:0]         cnt_q, cnt_d;
  logic               ready_q;
  entry_t             head_q, head_d, tail_q, tail_d, new_entry;

  // Multi-hot selects OR together; an all-zero select yields zero.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < els_p; k++)
      mux_data = mux_data | (pipe_io.data_i[k*width_p +: width_p] & {width_p{pipe_io.sel_one_hot_i[k]}});
  end

  if (check_one_hot_p != 0) begin : g_check
    localparam int pc_w = $clog2(els_p + 1);
    logic [pc_w-1:0]            ones;
    logic [err_cnt_width_p-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
      ones = '0;
      for (int k = 0; k < els_p; k++)
        ones = ones + pc_w'(pipe_io.sel_one_hot_i[k]);
    end
    assign sel_err = (ones != pc_w'(1));

    // Counted at enqueue time so a beat stuck in the buffer is already counted.
    always_comb begin
      err_cnt_d = err_cnt_q;
      if (enq && sel_err && (err_cnt_q != '1))
        err_cnt_d = err_cnt_q + err_cnt_width_p'(1);
    end

    always_ff @(posedge clk_i) begin
      if (!reset_n_i) err_cnt_q <= '0;
      else            err_cnt_q <= err_cnt_d;
    end
    assign pipe_io.err_cnt_o = err_cnt_q;
  end else begin : g_nocheck
    assign sel_err           = 1'b0;
    assign pipe_io.err_cnt_o = '0;
  end

  assign new_entry = '{err: sel_err, data: mux_data};
  assign enq       = pipe_io.v_i & ready_q;
  assign deq       = (cnt_q != 2'd0) & pipe_io.ready_i;

  // head_q is always the oldest entry; tail_q only holds data when cnt_q == 2.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case (cnt_q)
      2'd0: if (enq) begin
        head_d = new_entry;
        cnt_d  = 2'd1;
      end
      2'd1: if (enq && deq) begin
        head_d = new_entry;
      end else if (enq) begin
        tail_d = new_entry;
        cnt_d  = 2'd2;
      end else if (deq) begin
        cnt_d  = 2'd0;
      end
      2'd2: if (deq) begin
        head_d = tail_q;
        cnt_d  = 2'd1;
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_q   <= 2'd0;
      ready_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != 2'd2);
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign pipe_io.ready_o   = ready_q;
  assign pipe_io.v_o       = (cnt_q != 2'd0);
  assign pipe_io.data_o    = head_q.data;
  assign pipe_io.sel_err_o = head_q.err;

endmodule
